// File: rtl/cpu_timing_gen_pkg.sv
// Shared definitions for the BasicCPU timing generator.
// Contents: data width, default T-state count, T0 one-hot constant and
// the sequencer state encoding.
package cpu_timing_gen_pkg;

    localparam int DATA_WIDTH       = 8;
    localparam int DEFAULT_T_STATES = 6;

    // One-hot T0 at the default width; the top re-sizes it to its own width.
    localparam logic [DEFAULT_T_STATES-1:0] T0_ONEHOT = DEFAULT_T_STATES'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ARMED = 2'd2,
        ST_HALT  = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/cpu_timing_gen_edge_detect.sv
// 1-bit rising-edge detector in the clk domain.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset (clears the history register)
//   d     - level input
//   rise  - high while d is 1 and was 0 at the previous clock edge
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (reset) d_q <= 1'b0;
        else       d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/cpu_timing_gen.sv
// BasicCPU T-state sequencer. Turns rising edges of the divided clock
// (sampled as a level on clk_in) into one-hot T-state advances, with
// free-run, single-step and HLT-halt operation. Everything runs on clk_in.
// Ports:
//   clk_in    - system clock
//   reset     - synchronous active-high reset
//   clk_div   - divided clock level; each rising edge is a tick
//   run_mode  - 1 free run, 0 single-step
//   step      - step request level; rising edge arms one step
//   halt      - HLT decoded, sampled on a tick
//   end_instr - early end of instruction, sampled on a tick
//   t_state   - one-hot current T-state (bit 0 = T0)
//   cycle_en  - one-cycle strobe with each T-state update
//   halted    - sticky halt status
// Build option: define STEP_INSTR_EN to make one step run a whole
// instruction (until an advance lands on T0) instead of one T-state.
module cpu_timing_gen
    import cpu_timing_gen_pkg::*;
#(
    parameter int NUM_T_STATES = DEFAULT_T_STATES
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    clk_div,
    input  logic                    run_mode,
    input  logic                    step,
    input  logic                    halt,
    input  logic                    end_instr,
    output logic [NUM_T_STATES-1:0] t_state,
    output logic                    cycle_en,
    output logic                    halted
);

    localparam logic [NUM_T_STATES-1:0] T0 = NUM_T_STATES'(T0_ONEHOT);

    logic                    tick;
    logic                    step_rise;
    logic [NUM_T_STATES-1:0] t_next;
    fsm_state_t              state;

    edge_detect u_tick_det (
        .clk   (clk_in),
        .reset (reset),
        .d     (clk_div),
        .rise  (tick)
    );

    edge_detect u_step_det (
        .clk   (clk_in),
        .reset (reset),
        .d     (step),
        .rise  (step_rise)
    );

    // Wrap on the last T-state or on an early end of instruction.
    always_comb begin
        t_next = {t_state[NUM_T_STATES-2:0], 1'b0};
        if (end_instr || t_state[NUM_T_STATES-1]) t_next = T0;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state    <= ST_WAIT;
            t_state  <= T0;
            cycle_en <= 1'b0;
            halted   <= 1'b0;
        end else begin
            cycle_en <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (tick) begin
                        t_state  <= t_next;
                        cycle_en <= 1'b1;
                    end
                    // Halt takes effect only with the advance that completes the T-state.
                    if (tick && halt) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else if (!run_mode) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (run_mode)       state <= ST_RUN;
                    else if (step_rise) state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (tick) begin
                        t_state  <= t_next;
                        cycle_en <= 1'b1;
                        if (halt) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else if (run_mode) begin
                            state <= ST_RUN;
                        end else begin
`ifdef STEP_INSTR_EN
                            if (t_next == T0) state <= ST_WAIT;
`else
                            state <= ST_WAIT;
`endif
                        end
                    end else if (run_mode) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    // HALT: frozen until reset.
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_timing_gen.sv
module tb_cpu_timing_gen;

    localparam int N = 6;

    logic         clk_in = 1'b0;
    logic         reset, clk_div, run_mode, step, halt, end_instr;
    logic [N-1:0] t_state;
    logic         cycle_en, halted;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: phase index plus operating mode flags.
    int  m_idx;
    bit  m_cyc, m_halted, m_running, m_armed, m_div_prev, m_step_prev;

    bit  div_auto = 1'b0;
    int  div_cnt  = 0;
    int  pulses;

    cpu_timing_gen #(.NUM_T_STATES(N)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .clk_div   (clk_div),
        .run_mode  (run_mode),
        .step      (step),
        .halt      (halt),
        .end_instr (end_instr),
        .t_state   (t_state),
        .cycle_en  (cycle_en),
        .halted    (halted)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit tk, sr, adv;
        if (reset) begin
            m_idx = 0; m_cyc = 0; m_halted = 0; m_running = 0; m_armed = 0;
            m_div_prev = 0; m_step_prev = 0;
            return;
        end
        tk = clk_div && !m_div_prev;
        sr = step && !m_step_prev;
        m_div_prev  = clk_div;
        m_step_prev = step;
        adv   = !m_halted && tk && (m_running || m_armed);
        m_cyc = adv;
        if (adv) begin
            m_idx = (end_instr || m_idx == N-1) ? 0 : m_idx + 1;
            if (halt) m_halted = 1;
        end
        if (m_halted) begin
            m_running = 0; m_armed = 0;
        end else if (m_running) begin
            m_running = run_mode;
        end else if (m_armed) begin
            if (run_mode) begin
                m_running = 1; m_armed = 0;
            end
`ifdef STEP_INSTR_EN
            else if (adv && m_idx == 0) m_armed = 0;
`else
            else if (adv) m_armed = 0;
`endif
        end else if (run_mode) begin
            m_running = 1;
        end else if (sr) begin
            m_armed = 1;
        end
    endtask

    // One clk_in cycle: model at the edge, compare #1 later, then move clk_div.
    task automatic cyc_step();
        @(posedge clk_in);
        model_step();
        #1;
        check("t_state",  32'(t_state),  32'(1 << m_idx));
        check("cycle_en", 32'(cycle_en), 32'(m_cyc));
        check("halted",   32'(halted),   32'(m_halted));
        if (cycle_en) pulses++;
        if (div_auto) begin
            div_cnt++;
            if (div_cnt == 5) begin
                div_cnt = 0;
                clk_div = ~clk_div;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc_step();
    endtask

    task automatic run_until_idx(input int idx, input string tag);
        for (int i = 0; i < 200 && m_idx != idx; i++) cyc_step();
        check(tag, 32'(t_state), 32'(1 << idx));
    endtask

    initial begin
        reset = 1; clk_div = 0; run_mode = 0; step = 0; halt = 0; end_instr = 0;
        #1;
        run(2);
        reset = 0;

        // Free run across a full instruction and a wrap.
        run_mode = 1; div_auto = 1;
        run(140);

        // Early end of instruction while in T2.
        run_until_idx(2, "reach_T2");
        end_instr = 1;
        run(10);
        end_instr = 0;
        run(20);

        // Single-step: nothing without a step, one advance per step edge.
        reset = 1; run(1); reset = 0;
        run_mode = 0;
        pulses = 0;
        run(100);
        check("no_step_pulses", 32'(pulses), 32'd0);
        step = 1; run(1); step = 0;
        pulses = 0;
        run(25);
`ifndef STEP_INSTR_EN
        check("one_step_pulses", 32'(pulses), 32'd1);
`endif
        step = 1;
        pulses = 0;
        run(50);
`ifndef STEP_INSTR_EN
        check("held_step_pulses", 32'(pulses), 32'd1);
`endif
        step = 0;
        run(5);

        // Halt on the tick in T4.
        run_mode = 1;
        run_until_idx(4, "reach_T4");
        halt = 1;
        run(10);
        halt = 0;
        check("halt_T5", 32'(t_state), 32'(1 << (N-1)));
        check("halted_set", 32'(halted), 32'd1);
        run(30);
        reset = 1; run(1); reset = 0;
        check("halt_reset_t", 32'(t_state), 32'd1);
        check("halt_reset_h", 32'(halted), 32'd0);

        // Reset in T3 on the same cycle as a tick.
        run_until_idx(3, "reach_T3");
        div_auto = 0; clk_div = 0;
        run(2);
        clk_div = 1; reset = 1;
        run(1);
        reset = 0;
        check("reset_tick_t", 32'(t_state), 32'd1);
        check("reset_tick_c", 32'(cycle_en), 32'd0);
        div_auto = 1; div_cnt = 0;
        run(20);

`ifdef STEP_INSTR_EN
        reset = 1; run(1); reset = 0;
        run_mode = 0;
        run(10);
        step = 1; run(1); step = 0;
        pulses = 0;
        run(120);
        check("instr_step_pulses", 32'(pulses), 32'(N));
        check("instr_step_t0", 32'(t_state), 32'd1);
`endif

        // Randomized mix against the model.
        div_auto = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(3) == 0)  clk_div  = ~clk_div;
            if ($urandom_range(19) == 0) run_mode = ~run_mode;
            if ($urandom_range(9) == 0)  step     = ~step;
            halt      = ($urandom_range(39) == 0);
            end_instr = ($urandom_range(5) == 0);
            reset     = ($urandom_range(149) == 0);
            cyc_step();
        end
        reset = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_timing_gen.md
Name: cpu_timing_gen

Overview:
- Consumes `clk_out` of `clk_divider` as input `clk_div`, sampled synchronously on `clk_in`.
- Produces the BasicCPU one-hot T-state sequence plus a single-cycle `cycle_en` strobe for the control unit.
- Supports free-run, single-step and HLT-halt operation.
- `clk_div` is treated as a level; only its rising edges advance timing. Everything stays in the `clk_in` domain, with no derived clocks.

Parameters:
- NUM_T_STATES, 6, number of T-states per instruction (minimum 2).

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- clk_div  input  1  divided clock from `clk_divider`; its rising edge is a "tick".
- run_mode  input  1  1 = free run; 0 = single-step.
- step  input  1  step request level (button/debug); its rising edge arms one step.
- halt  input  1  HLT decoded by control; sampled only on a tick.
- end_instr  input  1  early end of instruction; sampled only on a tick.
- t_state  output  NUM_T_STATES  one-hot current T-state; bit 0 = T0.
- cycle_en  output  1  one-`clk_in`-cycle pulse coincident with each T-state update.
- halted  output  1  sticky halt status.

Behaviour:
- Tick detection:
  - `clk_div_q` registers `clk_div`.
  - `tick = clk_div & ~clk_div_q`.
  - At most one tick per `clk_div` period.
  - `clk_div` stuck high or low gives no ticks.
- Step detection: `step_q` registers `step`; `step_rise = step & ~step_q`.
- Reset (synchronous, priority over everything):
  - `t_state` = 1 (T0), `cycle_en` = 0, `halted` = 0.
  - FSM = WAIT; `clk_div_q` = 0, `step_q` = 0.
- FSM states: RUN, WAIT, ARMED, HALT.
- RUN:
  - On tick, advance.
  - If `run_mode` = 0 on any cycle, go to WAIT; the tick on that same cycle still advances.
- WAIT:
  - `run_mode` = 1 → RUN.
  - Else `step_rise` → ARMED.
  - Ticks are ignored; no advance.
- ARMED:
  - On tick, advance, then → WAIT.
  - `run_mode` = 1 → RUN (advance if tick).
  - Extra `step_rise` is ignored, not queued.
- HALT:
  - No advance; `cycle_en` stays 0.
  - `halted` = 1; exit only via reset.
- Advance, performed at the `clk_in` edge where tick is true in an advancing state:
  - `cycle_en` <= 1 for exactly one cycle.
  - If `end_instr` = 1 or `t_state` = T[N-1]: `t_state` <= T0 (wrap). Otherwise `t_state` rotates left by one.
  - If `halt` = 1: FSM → HALT and `halted` <= 1. The advance still occurs on that edge, so the CPU completes the current T-state.
- Latency: the new `t_state` and `cycle_en` are visible one `clk_in` cycle after the first sample of `clk_div` = 1.
- Simultaneous events:
  - `halt` and `end_instr` together → wrap to T0 and halt.
  - `halt` without a tick is ignored.
- `t_state` is always exactly one-hot, never zero, including after reset mid-instruction.
- `cycle_en` is 0 in every cycle without an advance.

Optional Feature:
- Macro: STEP_INSTR_EN.
- Defined: single-step granularity is one instruction.
  - ARMED keeps advancing on each tick until an advance lands on T0 (by wrap or `end_instr`), then → WAIT.
  - `halt` still wins.
- Undefined: granularity is one T-state, as above.

Decomposition:
- Shared package/defines file (alongside `DATA_WIDTH`):
  - FSM state encodings (2-bit: RUN, WAIT, ARMED, HALT).
  - T0 one-hot constant.
  - Default T-state count.
- Sub-module: `edge_detect` (1-bit rising-edge detector with synchronous reset), instantiated twice, for `clk_div` and `step`.

Test Plan:
- Reset, then `run_mode` = 1, `clk_div` toggling every 5 `clk_in` cycles → `t_state` 000001→000010→…→100000→000001; exactly one `cycle_en` pulse per `clk_div` rising edge, 10 `clk_in` cycles apart.
- `run_mode` = 1, `end_instr` = 1 on the tick while in T2 → next `t_state` = 000001; no T3 visited.
- `run_mode` = 0, `clk_div` free-running, no `step` → `t_state` stays 000001 with 0 `cycle_en` pulses over 100 cycles. One `step` pulse → exactly one advance to 000010 on the next tick. `step` held high for 50 cycles → still only one advance.
- `halt` = 1 on the tick in T4 → `t_state` = 100000 (T5), `halted` = 1, `cycle_en` = 0 thereafter. `reset` = 1 for one cycle → `t_state` = 000001, `halted` = 0.
- `reset` asserted mid-instruction (T3) in the same cycle as a tick → `t_state` = 000001 and `cycle_en` = 0 (reset wins).
- With STEP_INSTR_EN defined, `run_mode` = 0, one `step` pulse from T0 → 6 consecutive advances ending at T0, then no further advance.
